// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: two-port read arbiter in front of a fixed-latency ROM.
// Port 0 wins by default; port 1 is forced through after STARVE_MAX refused cycles.
module rom_read_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LAT:0]  tag_v_q, tag_v_d;
  logic [ROM_LAT:0]  tag_p_q, tag_p_d;
  logic              gnt0_s, gnt1_s;

  // Grant decode plus next-state for address, starvation counter and response tags
  always_comb begin
    gnt0_s     = 1'b0;
    gnt1_s     = 1'b0;
    rom_addr_d = rom_addr_q;
    starve_d   = 8'd0;
    if (!rst_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else begin
      gnt1_s = req1 & (~req0 | (starve_q == STARVE_LIM));
      gnt0_s = req0 & ~gnt1_s;
    end

    if (gnt1_s) begin
      rom_addr_d = addr1;
    end else if (gnt0_s) begin
      rom_addr_d = addr0;
    end else begin
      rom_addr_d = rom_addr_q;
    end

    if (req1 && !gnt1_s) begin
      if (starve_q == STARVE_LIM) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + 8'd1;
      end
    end else begin
      starve_d = 8'd0;
    end

    // Tag enters at the grant edge and reaches the top slot when ROM data is valid
    tag_v_d = {tag_v_q[ROM_LAT-1:0], gnt0_s | gnt1_s};
    tag_p_d = {tag_p_q[ROM_LAT-1:0], gnt1_s};
  end

  // State registers with synchronous reset; in-flight tags are dropped on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q   <= 8'd0;
      rom_addr_q <= '0;
      tag_v_q    <= '0;
      tag_p_q    <= '0;
    end else begin
      starve_q   <= starve_d;
      rom_addr_q <= rom_addr_d;
      tag_v_q    <= tag_v_d;
      tag_p_q    <= tag_p_d;
    end
  end

  assign gnt0     = gnt0_s;
  assign gnt1     = gnt1_s;
  assign rom_addr = rom_addr_q;
  assign rvalid0  = rst_n & tag_v_q[ROM_LAT] & ~tag_p_q[ROM_LAT];
  assign rvalid1  = rst_n & tag_v_q[ROM_LAT] & tag_p_q[ROM_LAT];
  assign rdata    = rom_data;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter: three instances (ROM_LAT 1, 2, 4; STARVE_MAX 3) share
// the same request stream and are compared every cycle against a scheduled-response model.
module tb_rom_read_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, req1;
  logic [16:0]       addr0, addr1;
  logic [2:0]        gnt0_w, gnt1_w, rvalid0_w, rvalid1_w;
  logic [2:0][11:0]  rdata_w, rom_data_w;
  logic [2:0][16:0]  rom_addr_w;

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_f(input logic [16:0] a);
    return a[11:0] ^ 12'hA5C;
  endfunction

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : (l == 1) ? 2 : 4;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [16:0] ap [4];

    rom_read_arbiter #(.ADDR_W(17), .DATA_W(12), .ROM_LAT(LAT), .STARVE_MAX(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .addr0(addr0), .gnt0(gnt0_w[g]), .rvalid0(rvalid0_w[g]),
      .req1(req1), .addr1(addr1), .gnt1(gnt1_w[g]), .rvalid1(rvalid1_w[g]),
      .rdata(rdata_w[g]), .rom_addr(rom_addr_w[g]), .rom_data(rom_data_w[g])
    );

    // ROM: samples rom_addr each edge, data appears LAT cycles after the sample
    always @(posedge clk) begin
      ap[0] <= rom_addr_w[g];
      for (int k = 1; k < 4; k++) ap[k] <= ap[k-1];
    end
    assign rom_data_w[g] = rom_f(ap[LAT-1]);
  end

  int n_chk = 0, n_pass = 0, cyc = 0, waited = 0;
  bit eg0, eg1;
  logic [16:0] exp_ra;
  bit          sv [3][16];
  bit          sp [3][16];
  logic [16:0] sa [3][16];
  bit [255:0]  h_g0, h_g1;
  bit [255:0]  h_rv0 [3];
  bit [255:0]  h_rv1 [3];
  logic [11:0] h_dat [3][256];
  logic [16:0] h_ra [256];

  task automatic chk(input string name, input int l, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s lane%0d cycle %0d: got %0h expected %0h", name, l, cyc, got, exp);
  endtask

  // One clock cycle: inputs already driven; compare at negedge, advance the model
  task automatic cycle();
    int slot, due;
    bit ev;
    @(negedge clk);
    eg1 = rst_n && req1 && (!req0 || waited == 3);
    eg0 = rst_n && req0 && !eg1;
    slot = cyc % 16;
    for (int l = 0; l < 3; l++) begin
      ev = sv[l][slot] && rst_n;
      chk("gnt0", l, 32'(gnt0_w[l]), 32'(eg0));
      chk("gnt1", l, 32'(gnt1_w[l]), 32'(eg1));
      chk("rom_addr", l, 32'(rom_addr_w[l]), 32'(exp_ra));
      chk("rvalid0", l, 32'(rvalid0_w[l]), 32'(ev && !sp[l][slot]));
      chk("rvalid1", l, 32'(rvalid1_w[l]), 32'(ev && sp[l][slot]));
      if (ev) chk("rdata", l, 32'(rdata_w[l]), 32'(rom_f(sa[l][slot])));
      h_rv0[l][cyc] = rvalid0_w[l];
      h_rv1[l][cyc] = rvalid1_w[l];
      h_dat[l][cyc] = rdata_w[l];
      sv[l][slot] = 1'b0;
    end
    h_g0[cyc] = gnt0_w[0];
    h_g1[cyc] = gnt1_w[0];
    h_ra[cyc] = rom_addr_w[0];
    for (int l = 0; l < 3; l++) begin
      if (!rst_n) begin
        for (int s = 0; s < 16; s++) sv[l][s] = 1'b0;
      end else if (eg0 || eg1) begin
        due = (cyc + 1 + lat_of(l)) % 16;
        sv[l][due] = 1'b1;
        sp[l][due] = eg1;
        sa[l][due] = eg1 ? addr1 : addr0;
      end
    end
    if (!rst_n) exp_ra = 17'h0;
    else if (eg1) exp_ra = addr1;
    else if (eg0) exp_ra = addr0;
    if (!rst_n) waited = 0;
    else if (req1 && !eg1) waited = (waited < 3) ? waited + 1 : 3;
    else waited = 0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req0 = 1'b0; req1 = 1'b0;
    addr0 = 17'h1FFFF; addr1 = 17'h1FFFF;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int t, s0;
    exp_ra = 17'h0;
    for (int l = 0; l < 3; l++)
      for (int s = 0; s < 16; s++) begin sv[l][s] = 1'b0; sp[l][s] = 1'b0; sa[l][s] = 17'h0; end
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = 17'h0; addr1 = 17'h0;
    @(posedge clk);
    #1;

    // Reset with both requesting, then continuous contention for starvation pattern
    req0 = 1'b1; req1 = 1'b1; addr0 = 17'h00020; addr1 = 17'h00200;
    cycle(); cycle();
    chk("pin_rst_gnt", 0, 32'({h_g0[1:0], h_g1[1:0]}), 32'h0);
    rst_n = 1'b1;
    s0 = cyc;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (eg0) addr0 = addr0 + 17'h1;
      if (eg1) addr1 = addr1 + 17'h1;
    end
    chk("pin_rst_romaddr", 0, 32'(h_ra[s0]), 32'h0);
    chk("pin_starve_gnt", 0, 32'(h_g1[s0 +: 12]), 32'h888);
    chk("pin_starve_rv", 0, 32'(h_rv1[0][s0 +: 12]), 32'h220);
    idle(8);

    // Single read at 0x00010
    t = cyc;
    req0 = 1'b1; addr0 = 17'h00010;
    cycle();
    idle(8);
    chk("pin_single_romaddr", 0, 32'(h_ra[t+1]), 32'h10);
    chk("pin_single_rv", 0, 32'(h_rv0[0][t +: 8]), 32'h04);
    chk("pin_single_rv", 1, 32'(h_rv0[1][t +: 8]), 32'h08);
    chk("pin_single_rv", 2, 32'(h_rv0[2][t +: 8]), 32'h20);
    for (int l = 0; l < 3; l++)
      chk("pin_single_data", l, 32'(h_dat[l][t+1+lat_of(l)]), 32'hA4C);

    // Port 1 streaming 0x100..0x103
    t = cyc;
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr1 = 17'h00100 + 17'(i);
      cycle();
    end
    idle(9);
    chk("pin_stream_gnt", 0, 32'(h_g1[t +: 4]), 32'hF);
    chk("pin_stream_rv", 0, 32'(h_rv1[0][t +: 8]), 32'h3C);
    chk("pin_stream_d0", 0, 32'(h_dat[0][t+2]), 32'hB5C);
    chk("pin_stream_d3", 0, 32'(h_dat[0][t+5]), 32'hB5F);

    // Reset one cycle after a port-0 grant discards the read
    t = cyc;
    req0 = 1'b1; addr0 = 17'h00030;
    cycle();
    req0 = 1'b0; rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    idle(8);
    for (int l = 0; l < 3; l++)
      chk("pin_midreset_rv", l, 32'(h_rv0[l][t+1 +: 6]), 32'h0);

    // Mixed traffic with held requests until granted
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (eg0 || !req0) begin req0 = 1'($urandom_range(0, 1)); addr0 = 17'($urandom); end
      if (eg1 || !req1) begin req1 = 1'($urandom_range(0, 1)); addr1 = 17'($urandom); end
    end
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rom_read_arbiter.md
ROM_READ_ARBITER -- requirements
Module: rom_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 12, ROM data width (RGB444 pixel).
REQ-003 SHALL have parameter ROM_LAT, default 1, legal 1..4, cycles from ROM address sample to ROM data valid.
REQ-004 SHALL have parameter STARVE_MAX, default 15, legal 1..255, port-1 wait cycles before a forced port-1 grant.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-007 SHALL have port req0, input, 1, port-0 (VGA pixel fetch) read request.
REQ-008 SHALL have port addr0, input, ADDR_W, port-0 read address.
REQ-009 SHALL have port gnt0, output, 1, port-0 request accepted this cycle.
REQ-010 SHALL have port rvalid0, output, 1, rdata holds port-0 response this cycle.
REQ-011 SHALL have ports req1, addr1, gnt1, rvalid1, same widths and meaning, for port 1 (sprite/overlay fetch).
REQ-012 SHALL have port rdata, output, DATA_W, shared response data.
REQ-013 SHALL have port rom_addr, output, ADDR_W, registered address to the ROM wrapper.
REQ-014 SHALL have port rom_data, input, DATA_W, ROM wrapper output data.

Function
REQ-015 SHALL treat a request as pending while reqN=1; requester holds reqN and addrN stable until it sees gntN=1 in the same cycle.
REQ-016 SHALL drive gnt0/gnt1 combinationally from req0, req1 and starve_cnt; at most one grant per cycle.
REQ-017 SHALL grant port 1 when req1=1 and (req0=0 or starve_cnt==STARVE_MAX); otherwise grant port 0 when req0=1.
REQ-018 SHALL keep a starvation counter starve_cnt: +1 at each edge where req1=1 and gnt1=0, saturating at STARVE_MAX; cleared at each edge where gnt1=1 or req1=0.
REQ-019 SHALL on a granted cycle t load rom_addr at edge t with the granted port's address; with no grant rom_addr SHALL hold its value.
REQ-020 SHALL carry a (valid, port id) tag through a shift pipeline of depth ROM_LAT+1, entered at edge t.
REQ-021 SHALL assert rvalidN for exactly one cycle, cycle t+1+ROM_LAT, for the port granted in cycle t; never both rvalid0 and rvalid1 together.
REQ-022 SHALL drive rdata = rom_data combinationally; rdata is don't-care when neither rvalid is 1.
REQ-023 SHALL sustain one grant per cycle; responses return in grant order with no bubbles beyond those in the grant stream.
REQ-024 SHALL ignore addrN when reqN=0; simultaneous req0 and req1 SHALL resolve per REQ-017 without loss of the non-granted request (it stays pending).

Reset
REQ-025 SHALL on any edge with rst_n=0 clear rom_addr to 0, starve_cnt to 0, and all pipeline valid bits to 0.
REQ-026 SHALL hold gnt0, gnt1, rvalid0, rvalid1 at 0 in any cycle where rst_n=0.
REQ-027 SHALL discard reads in flight at reset; no rvalid for any grant issued before or during reset.

Verification
REQ-028 Reset: rst_n=0 for 2 cycles with req0=req1=1 -> gnt0=gnt1=rvalid0=rvalid1=0, rom_addr=0x00000 after release edge.
REQ-029 Single read: ROM_LAT=1, req0=1, addr0=0x00010 in cycle t -> gnt0=1 cycle t, rom_addr=0x00010 cycle t+1, rvalid0=1 and rdata=ROM[0x00010] cycle t+2 only.
REQ-030 Starvation: STARVE_MAX=3, req0=req1=1 continuous from reset release -> grant sequence 0,0,0,1,0,0,0,1; rvalid pattern identical, delayed by ROM_LAT+1.
REQ-031 Streaming: req1 alone, addr1=0x100..0x103 over 4 consecutive cycles -> gnt1=1 all 4 cycles, rvalid1=1 4 consecutive cycles, rdata=ROM[0x100..0x103] in order.
REQ-032 Reset mid-flight: grant port 0 in cycle t, rst_n=0 in cycle t+1 -> rvalid0=0 in cycles t+1..t+4.
REQ-033 Latency sweep: ROM_LAT=2 and 4 with the REQ-029 stimulus -> rvalid0 in cycle t+3 and t+5 respectively, correct data.
